// File: rtl/alarm_bank_ctrl.sv
// Alarm bank: NUM_ALARMS BCD alarm slots compared against an RTC time
// stream. One IDLE/RING/SNOOZE sequencer drives buzzer tone and LED chaser.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   hours, minutes, seconds         BCD time from the RTC reader
//   time_valid                      strobe: time inputs hold a new sample
//   cfg_we, cfg_idx                 slot write strobe and slot index
//   cfg_hour, cfg_min, cfg_en       slot contents
//   stop, snooze                    user pulses
//   buzzer, ringing, snoozing       tone output and state flags
//   active_idx                      slot that is ringing or snoozed
//   leds                            one-hot chaser while ringing
module alarm_bank_ctrl #(
  parameter int NUM_ALARMS = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int TONE_HZ    = 2000,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_MIN = 5,
  parameter int NLEDS      = 7,
  localparam int IDX_W =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       hours,
  input  logic [7:0]       minutes,
  input  logic [7:0]       seconds,
  input  logic             time_valid,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_hour,
  input  logic [7:0]       cfg_min,
  input  logic             cfg_en,
  input  logic             stop,
  input  logic             snooze,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [IDX_W-1:0] active_idx,
  output logic [NLEDS-1:0] leds
);

  localparam int HALF_RAW = CLK_HZ / (2 * TONE_HZ);
  localparam int HALF = (HALF_RAW > 0) ? HALF_RAW : 1;
  localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int SNZ = SNOOZE_MIN * 60;
  localparam int SW = (SNZ > 1) ? $clog2(SNZ + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  state_t state;

  logic [7:0] slot_hour [NUM_ALARMS];
  logic [7:0] slot_min  [NUM_ALARMS];
  logic       slot_en   [NUM_ALARMS];

  logic [7:0]    sec_q;
  logic          sec_seen;
  logic [TW-1:0] tone_cnt;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;

  logic             tick;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             kill;
  logic             trig;

  // Tick only once a previous sample exists to compare against.
  assign tick = time_valid && sec_seen &&
                (seconds != sec_q);

  assign trig = tick && (seconds == 8'h00) && hit;

  assign kill = cfg_we && !cfg_en &&
                (cfg_idx == active_idx);

  // Scan downward so the lowest matching slot is the last write.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (slot_en[i] &&
          slot_hour[i] == hours &&
          slot_min[i] == minutes) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sec_q      <= '0;
      sec_seen   <= 1'b0;
      tone_cnt   <= '0;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      active_idx <= '0;
      leds       <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hour[i] <= '0;
        slot_min[i]  <= '0;
        slot_en[i]   <= 1'b0;
      end
    end else begin
      if (time_valid) begin
        sec_q    <= seconds;
        sec_seen <= 1'b1;
      end

      // Per-slot compare keeps out-of-range indices harmless.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          slot_hour[i] <= cfg_hour;
          slot_min[i]  <= cfg_min;
          slot_en[i]   <= cfg_en;
        end
      end

      unique case (state)
        IDLE: begin
          if (trig) begin
            state      <= RING;
            active_idx <= hit_idx;
            ringing    <= 1'b1;
            leds       <= NLEDS'(1);
            buzzer     <= 1'b0;
            tone_cnt   <= '0;
            ring_cnt   <= '0;
          end
        end

        RING: begin
          if (stop || kill) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            buzzer   <= 1'b0;
            leds     <= '0;
            tone_cnt <= '0;
            ring_cnt <= '0;
          end else if (snooze) begin
            state    <= SNOOZE;
            snz_cnt  <= SW'(SNZ);
            snoozing <= 1'b1;
            ringing  <= 1'b0;
            buzzer   <= 1'b0;
            leds     <= '0;
            tone_cnt <= '0;
            ring_cnt <= '0;
          end else if (tick &&
                       ring_cnt == RW'(RING_SEC - 1)) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            buzzer   <= 1'b0;
            leds     <= '0;
            tone_cnt <= '0;
            ring_cnt <= '0;
          end else begin
            if (tone_cnt == TW'(HALF - 1)) begin
              tone_cnt <= '0;
              buzzer   <= ~buzzer;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
            if (tick) begin
              ring_cnt <= ring_cnt + 1'b1;
              leds <= (leds << 1) | (leds >> (NLEDS - 1));
            end
          end
        end

        SNOOZE: begin
          if (stop || kill) begin
            state    <= IDLE;
            snoozing <= 1'b0;
            snz_cnt  <= '0;
          end else if (tick) begin
            if (snz_cnt <= SW'(1)) begin
              state    <= RING;
              snoozing <= 1'b0;
              snz_cnt  <= '0;
              ringing  <= 1'b1;
              leds     <= NLEDS'(1);
              buzzer   <= 1'b0;
              tone_cnt <= '0;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt - 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
          buzzer   <= 1'b0;
          leds     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// Directed bench for alarm_bank_ctrl with small timing parameters.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_alarm_bank_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       time_valid;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_hour;
  logic [7:0] cfg_min;
  logic       cfg_en;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] active_idx;
  logic [6:0] leds;

  int tests;
  int fails;

  alarm_bank_ctrl #(
    .NUM_ALARMS(4),
    .CLK_HZ(1000),
    .TONE_HZ(100),
    .RING_SEC(3),
    .SNOOZE_MIN(1),
    .NLEDS(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hours(hours),
    .minutes(minutes),
    .seconds(seconds),
    .time_valid(time_valid),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_hour(cfg_hour),
    .cfg_min(cfg_min),
    .cfg_en(cfg_en),
    .stop(stop),
    .snooze(snooze),
    .buzzer(buzzer),
    .ringing(ringing),
    .snoozing(snoozing),
    .active_idx(active_idx),
    .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send_time(input logic [7:0] h,
                           input logic [7:0] m,
                           input logic [7:0] s);
    hours = h;
    minutes = m;
    seconds = s;
    time_valid = 1'b1;
    step();
    time_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx,
                           input logic [7:0] h,
                           input logic [7:0] m,
                           input logic en);
    cfg_idx = idx;
    cfg_hour = h;
    cfg_min = m;
    cfg_en = en;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  // Two samples so the 00 sample is a real second tick at 07:30.
  task automatic ring_0730();
    send_time(8'h07, 8'h29, 8'h59);
    send_time(8'h07, 8'h30, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({ringing, snoozing, buzzer, active_idx, leds} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs: r=%b s=%b b=%b idx=%0d leds=%b want all 0",
               ringing, snoozing, buzzer, active_idx, leds);
    end
  endtask

  task automatic test_first_sample();
    do_reset();
    cfg_write(2'd0, 8'h07, 8'h30, 1'b1);
    send_time(8'h07, 8'h30, 8'h00);
    tests++;
    if (ringing !== 1'b0) begin
      fails++;
      $display("FAIL first_sample_no_tick: ringing=%b want 0", ringing);
    end
  endtask

  task automatic test_ring_entry();
    logic exp_b;
    int bad;
    do_reset();
    cfg_write(2'd2, 8'h07, 8'h30, 1'b1);
    ring_0730();
    tests++;
    if (ringing !== 1'b1 || active_idx !== 2'd2) begin
      fails++;
      $display("FAIL ring_entry: ringing=%b idx=%0d want 1 idx 2",
               ringing, active_idx);
    end
    tests++;
    if (leds !== 7'b0000001) begin
      fails++;
      $display("FAIL ring_leds: leds=%b want 0000001", leds);
    end
    // Half period is 5 clocks: low 5, high 5, repeating.
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      exp_b = ((k / 5) % 2) == 1;
      if (buzzer !== exp_b) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL buzzer_period: %0d of 20 samples wrong, want period 10",
               bad);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_write(2'd2, 8'h07, 8'h30, 1'b1);
    ring_0730();
    send_time(8'h07, 8'h30, 8'h01);
    tests++;
    if (leds !== 7'b0000010 || ringing !== 1'b1) begin
      fails++;
      $display("FAIL leds_tick1: leds=%b ringing=%b want 0000010 1",
               leds, ringing);
    end
    send_time(8'h07, 8'h30, 8'h02);
    tests++;
    if (leds !== 7'b0000100 || ringing !== 1'b1) begin
      fails++;
      $display("FAIL leds_tick2: leds=%b ringing=%b want 0000100 1",
               leds, ringing);
    end
    send_time(8'h07, 8'h30, 8'h03);
    tests++;
    if (ringing !== 1'b0 || leds !== 7'd0 || buzzer !== 1'b0) begin
      fails++;
      $display("FAIL ring_timeout: r=%b leds=%b b=%b want 0 0 0",
               ringing, leds, buzzer);
    end
  endtask

  task automatic test_lowest_index();
    do_reset();
    cfg_write(2'd1, 8'h07, 8'h30, 1'b1);
    cfg_write(2'd3, 8'h07, 8'h30, 1'b1);
    ring_0730();
    tests++;
    if (ringing !== 1'b1 || active_idx !== 2'd1) begin
      fails++;
      $display("FAIL lowest_index: ringing=%b idx=%0d want 1 idx 1",
               ringing, active_idx);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int s = 1; s <= 5; s++) send_time(8'h07, 8'h30, 8'(s));
    tests++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin
      fails++;
      $display("FAIL slot3_never_rings: r=%b s=%b want 0 0",
               ringing, snoozing);
    end
  endtask

  task automatic test_snooze();
    do_reset();
    cfg_write(2'd2, 8'h07, 8'h30, 1'b1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    tests++;
    if (snoozing !== 1'b0) begin
      fails++;
      $display("FAIL snooze_in_idle: snoozing=%b want 0", snoozing);
    end
    ring_0730();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    tests++;
    if (snoozing !== 1'b1 || ringing !== 1'b0 || leds !== 7'd0) begin
      fails++;
      $display("FAIL snooze_enter: s=%b r=%b leds=%b want 1 0 0",
               snoozing, ringing, leds);
    end
    for (int t = 1; t <= 59; t++)
      send_time(8'h07, 8'h30, (t % 2 == 1) ? 8'h11 : 8'h22);
    tests++;
    if (snoozing !== 1'b1 || ringing !== 1'b0) begin
      fails++;
      $display("FAIL snooze_59_ticks: s=%b r=%b want 1 0",
               snoozing, ringing);
    end
    send_time(8'h07, 8'h30, 8'h33);
    tests++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || active_idx !== 2'd2 ||
        leds !== 7'b0000001) begin
      fails++;
      $display("FAIL snooze_reRing: r=%b s=%b idx=%0d leds=%b want 1 0 2 0000001",
               ringing, snoozing, active_idx, leds);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++;
    if (snoozing !== 1'b0 || ringing !== 1'b0) begin
      fails++;
      $display("FAIL stop_in_snooze: s=%b r=%b want 0 0",
               snoozing, ringing);
    end
  endtask

  task automatic test_stop_snooze_same();
    do_reset();
    cfg_write(2'd2, 8'h07, 8'h30, 1'b1);
    ring_0730();
    stop = 1'b1;
    snooze = 1'b1;
    step();
    stop = 1'b0;
    snooze = 1'b0;
    tests++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin
      fails++;
      $display("FAIL stop_wins: r=%b s=%b want 0 0", ringing, snoozing);
    end
  endtask

  task automatic test_disable_and_reset();
    do_reset();
    cfg_write(2'd0, 8'h07, 8'h30, 1'b1);
    ring_0730();
    cfg_write(2'd1, 8'h07, 8'h30, 1'b0);
    tests++;
    if (ringing !== 1'b1 || active_idx !== 2'd0) begin
      fails++;
      $display("FAIL other_slot_disable: r=%b idx=%0d want 1 idx 0",
               ringing, active_idx);
    end
    cfg_write(2'd0, 8'h07, 8'h30, 1'b0);
    tests++;
    if (ringing !== 1'b0 || leds !== 7'd0) begin
      fails++;
      $display("FAIL active_disable: r=%b leds=%b want 0 0", ringing, leds);
    end
    cfg_write(2'd2, 8'h07, 8'h31, 1'b1);
    send_time(8'h07, 8'h30, 8'h59);
    send_time(8'h07, 8'h31, 8'h00);
    tests++;
    if (ringing !== 1'b1 || active_idx !== 2'd2) begin
      fails++;
      $display("FAIL ring_before_reset: r=%b idx=%0d want 1 idx 2",
               ringing, active_idx);
    end
    repeat (7) step();
    rst_n = 1'b0;
    step();
    tests++;
    if ({ringing, snoozing, buzzer, active_idx, leds} !== 12'd0) begin
      fails++;
      $display("FAIL reset_mid_ring: r=%b s=%b b=%b idx=%0d leds=%b want all 0",
               ringing, snoozing, buzzer, active_idx, leds);
    end
    rst_n = 1'b1;
    send_time(8'h07, 8'h31, 8'h00);
    send_time(8'h07, 8'h31, 8'h01);
    tests++;
    if (ringing !== 1'b0) begin
      fails++;
      $display("FAIL no_retrigger: ringing=%b want 0", ringing);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    hours = '0;
    minutes = '0;
    seconds = '0;
    time_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_hour = '0;
    cfg_min = '0;
    cfg_en = 1'b0;
    stop = 1'b0;
    snooze = 1'b0;
    test_reset();
    test_first_sample();
    test_ring_entry();
    test_timeout();
    test_lowest_index();
    test_snooze();
    test_stop_snooze_same();
    test_disable_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
